// File: rtl/alu32_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions, output-stage state encoding and entry layout.
package alu32_pkg;

  localparam int ALU_W = 32;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic [3:0]       flags;
  } entry_t;

endpackage

// File: rtl/alu32_flag_gen.sv
// Combinational {N,Z,C,V} derivation from an ALU result; C/V are only meaningful for ADD/SUB.
module alu32_flag_gen
  import alu32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] result,
  input  logic [2:0]       op,
  input  logic             co,
  input  logic             ovf,
  output logic [3:0]       flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    // Logic ops leave carry/overflow lines undefined, so they are masked.
    if ((op == OP_ADD) || (op == OP_SUB)) begin
      flags[FLAG_C] = co;
      flags[FLAG_V] = ovf;
    end
  end

endmodule

// File: rtl/alu32_out_stage.sv
// ALU result capture: 2-entry skid buffer, 1-cycle latency, in_ready depends only on occupancy (never out_ready).
// Define ALU_OUT_STICKY_EN to accumulate popped C/V into sticky_flags; otherwise sticky_flags is tied low.
module alu32_out_stage
  import alu32_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [2:0]       in_op,
  input  logic             in_co,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  input  logic             sticky_clr,
  output logic [1:0]       sticky_flags,
  output logic [1:0]       occupancy
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
  } slot_t;

  generate
    if (DEPTH != 2) begin : g_depth_chk
      $error("alu32_out_stage supports DEPTH == 2 only");
    end
  endgenerate

  state_e     state_q, state_d;
  slot_t      head_q, head_d;
  slot_t      tail_q, tail_d;
  slot_t      in_slot;
  logic [3:0] in_flags;
  logic       push;
  logic       pop;

  alu32_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result (in_result),
    .op     (in_op),
    .co     (in_co),
    .ovf    (in_ovf),
    .flags  (in_flags)
  );

  assign in_slot = {in_result, in_flags};

  // Handshake outputs decode the state register only, so they are glitch-free and registered.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = in_slot;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = in_slot;
        end else if (push) begin
          tail_d  = in_slot;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_result = head_q.result;
  assign out_flags  = head_q.flags;

`ifdef ALU_OUT_STICKY_EN
  logic [1:0] sticky_q, sticky_d;

  // A clear beats a coincident pop; the popped C/V are dropped.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) begin
      sticky_d = 2'b00;
    end else if (pop) begin
      sticky_d = sticky_q | {head_q.flags[FLAG_C], head_q.flags[FLAG_V]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 2'b00;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = 2'b00;
`endif

endmodule

// File: tb/tb_alu32_out_stage.sv
// Bench for alu32_out_stage: directed scenarios plus random traffic checked against a queue model.
module tb_alu32_out_stage;
  import alu32_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [2:0]  in_op;
  logic        in_co;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        sticky_clr;
  logic [1:0]  sticky_flags;
  logic [1:0]  occupancy;

  always #5 clk = ~clk;

  alu32_out_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_op        (in_op),
    .in_co        (in_co),
    .in_ovf       (in_ovf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags),
    .occupancy    (occupancy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: an in-order queue of (result, flags) plus sticky bits.
  entry_t      m_q[$];
  logic [1:0]  m_sticky = 2'b00;
  bit          m_fresh  = 1'b1;
  int          m_pops   = 0;
  logic [31:0] dut_pops[$];

  function automatic logic [3:0] ref_flags(logic [31:0] r, logic [2:0] op, bit co, bit ov);
    bit arith;
    bit n;
    bit z;
    arith = (op == OP_ADD) || (op == OP_SUB);
    n     = (r >= 32'h8000_0000);
    z     = (r == 32'd0);
    return {n, z, arith & co, arith & ov};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, logic [2:0] op, logic [31:0] r, bit co, bit ov,
                       bit ordy, bit clr, bit rst);
    in_valid   = v;
    in_op      = op;
    in_result  = r;
    in_co      = co;
    in_ovf     = ov;
    out_ready  = ordy;
    sticky_clr = clr;
    reset      = rst;
  endtask

  task automatic cycle();
    bit     push;
    bit     pop;
    entry_t e;
    push = in_valid && (m_q.size() < 2);
    pop  = out_ready && (m_q.size() > 0);
    if (out_valid && out_ready) dut_pops.push_back(out_result);
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_sticky = 2'b00;
      m_fresh  = 1'b1;
    end else begin
`ifdef ALU_OUT_STICKY_EN
      if (sticky_clr) m_sticky = 2'b00;
      else if (pop)   m_sticky = m_sticky | m_q[0].flags[1:0];
`endif
      if (pop) begin
        void'(m_q.pop_front());
        m_pops++;
      end
      if (push) begin
        e.result = in_result;
        e.flags  = ref_flags(in_result, in_op, in_co, in_ovf);
        m_q.push_back(e);
        m_fresh = 1'b0;
      end
    end
    #1;
    check("occupancy", occupancy, m_q.size());
    check("in_ready", in_ready, m_q.size() < 2);
    check("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("out_result", out_result, m_q[0].result);
      check("out_flags", out_flags, m_q[0].flags);
    end else if (m_fresh) begin
      check("reset_result", out_result, 0);
      check("reset_flags", out_flags, 0);
    end
    check("sticky_flags", sticky_flags, m_sticky);
  endtask

  initial begin
    int          pops0;
    logic [1:0]  exp_sticky;
    logic [31:0] r;

    drive(0, OP_ADD, 32'h0, 0, 0, 0, 0, 1);
    cycle();
    cycle();
    drive(0, OP_ADD, 32'h0, 0, 0, 0, 0, 0);
    cycle();

    // ADD zero result with carry: Z and C set.
    drive(1, OP_ADD, 32'h0000_0000, 1, 0, 0, 0, 0);
    cycle();
    check("t1_valid", out_valid, 1);
    check("t1_result", out_result, 32'h0);
    check("t1_flags", out_flags, 4'b0110);

    // AND with MSB set: C/V masked; previous entry leaves in the same cycle.
    drive(1, OP_AND, 32'h8000_0000, 1, 1, 1, 0, 0);
    cycle();
    check("t2_flags", out_flags, 4'b1000);
    check("t2_occ", occupancy, 2'd1);
    drive(0, OP_ADD, 32'h0, 0, 0, 1, 1, 0);
    cycle();
    check("t2_drained", out_valid, 0);

    // Backpressure: third entry must be held upstream until space frees up.
    dut_pops.delete();
    drive(1, OP_OR, 32'h1, 0, 0, 0, 0, 0);
    cycle();
    drive(1, OP_OR, 32'h2, 0, 0, 0, 0, 0);
    cycle();
    check("t3_full_ready", in_ready, 0);
    check("t3_full_occ", occupancy, 2'd2);
    drive(1, OP_OR, 32'h3, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    check("t3_held_occ", occupancy, 2'd2);
    check("t3_held_head", out_result, 32'h1);
    drive(1, OP_OR, 32'h3, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cycle();
    drive(0, OP_OR, 32'h0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cycle();
    check("t3_pop_count", dut_pops.size(), 3);
    for (int i = 0; i < 3 && i < dut_pops.size(); i++) check("t3_order", dut_pops[i], i + 1);

    // Streaming at full rate: one push and one pop per cycle.
    dut_pops.delete();
    pops0 = m_pops;
    for (int i = 0; i < 16; i++) begin
      drive(1, OP_SUB, 32'h10 + i, i[0], i[1], 1, 0, 0);
      cycle();
      check("t4_occ", occupancy, 2'd1);
      check("t4_valid", out_valid, 1);
    end
    drive(0, OP_SUB, 32'h0, 0, 0, 1, 0, 0);
    cycle();
    check("t4_pops", m_pops - pops0, 16);
    check("t4_dut_pops", dut_pops.size(), 16);
    for (int i = 0; i < 16 && i < dut_pops.size(); i++) check("t4_order", dut_pops[i], 32'h10 + i);

    // Reset while full with a push attempted in the same cycle.
    dut_pops.delete();
    drive(1, OP_XOR, 32'hAA, 0, 0, 0, 0, 0);
    cycle();
    drive(1, OP_XOR, 32'hBB, 0, 0, 0, 0, 0);
    cycle();
    drive(1, OP_XOR, 32'hCC, 0, 0, 0, 0, 1);
    cycle();
    check("t5_occ", occupancy, 2'd0);
    check("t5_valid", out_valid, 0);
    check("t5_ready", in_ready, 1);
    drive(0, OP_XOR, 32'h0, 0, 0, 1, 0, 0);
    cycle();
    check("t5_no_emit", dut_pops.size(), 0);

    // Sticky accumulation and clear-over-pop priority.
    drive(0, OP_ADD, 32'h0, 0, 0, 1, 1, 0);
    cycle();
    drive(1, OP_ADD, 32'h5, 0, 1, 1, 0, 0);
    cycle();
    drive(1, OP_OR, 32'h7, 0, 0, 1, 0, 0);
    cycle();
    drive(0, OP_OR, 32'h0, 0, 0, 1, 0, 0);
    cycle();
`ifdef ALU_OUT_STICKY_EN
    exp_sticky = 2'b01;
`else
    exp_sticky = 2'b00;
`endif
    check("t6_sticky_v", sticky_flags, exp_sticky);
    drive(1, OP_ADD, 32'h1, 1, 0, 1, 0, 0);
    cycle();
    drive(0, OP_ADD, 32'h0, 0, 0, 1, 1, 0);
    cycle();
    check("t6_clear_wins", sticky_flags, 2'b00);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 32'h0;
        1:       r = 32'h8000_0000 | $urandom;
        default: r = $urandom;
      endcase
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), r,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
